// File: rtl/card_select_ctrl_pkg.sv
// Shared constants, FSM encoding and slot indexing for the card selection controller.
package card_select_ctrl_pkg;

    localparam int COLS   = 18;
    localparam int ROWS   = 8;
    localparam int SLOTS  = COLS * ROWS;
    localparam int CARD_W = 6;
    localparam int X_W    = 5;
    localparam int Y_W    = 3;
    localparam int IDX_W  = 8;

    localparam logic [CARD_W-1:0] EMPTY_CARD = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] slot_idx(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        return IDX_W'(x) + IDX_W'(y) * IDX_W'(COLS);
    endfunction

endpackage

// File: rtl/card_select_ctrl_cursor_axis.sv
// Wrap-around up/down counter for one cursor axis; inc and dec together hold the value.
module cursor_axis
    import card_select_ctrl_pkg::*;
#(
    parameter int LIMIT = 17,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (en && (inc ^ dec)) begin
            if (inc) begin
                value <= (value == W'(LIMIT)) ? '0 : value + W'(1);
            end else begin
                value <= (value == '0) ? W'(LIMIT) : value - W'(1);
            end
        end
    end

endmodule

// File: rtl/card_select_ctrl.sv
// Cursor/selection controller with row-wise clear sweep and commit handshake.
// Optional: CARD_SEL_SKIP_EMPTY_EN blocks setting the selection on empty (type 0) slots.
module card_select_ctrl
    import card_select_ctrl_pkg::*;
#(
    parameter int COLS   = card_select_ctrl_pkg::COLS,
    parameter int ROWS   = card_select_ctrl_pkg::ROWS,
    parameter int CARD_W = card_select_ctrl_pkg::CARD_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [COLS*ROWS*CARD_W-1:0] map,
    input  logic                        mv_up,
    input  logic                        mv_down,
    input  logic                        mv_left,
    input  logic                        mv_right,
    input  logic                        toggle,
    input  logic                        clear_all,
    input  logic                        commit_req,
    input  logic                        commit_ack,
    output logic [COLS*ROWS-1:0]        sel_card,
    output logic [4:0]                  cursor_x,
    output logic [2:0]                  cursor_y,
    output logic [7:0]                  sel_count,
    output logic                        commit_valid,
    output logic                        busy
);

    localparam int ROW_W = $clog2(ROWS);

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COLS*ROWS-1:0]  sel_d;
    logic [7:0]            count_d;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_bit;
    logic                  set_allowed;
    logic                  tog_ok;
    logic                  move_en;

    assign move_en = (state_q == ST_IDLE);

    cursor_axis #(.LIMIT(COLS - 1)) u_axis_x (
        .clk   (clk),
        .rst   (rst),
        .en    (move_en),
        .inc   (mv_right),
        .dec   (mv_left),
        .value (cursor_x)
    );

    // Row 0 is the top, so "down" counts up.
    cursor_axis #(.LIMIT(ROWS - 1)) u_axis_y (
        .clk   (clk),
        .rst   (rst),
        .en    (move_en),
        .inc   (mv_down),
        .dec   (mv_up),
        .value (cursor_y)
    );

    assign cur_idx = slot_idx(cursor_x, cursor_y);
    assign cur_bit = sel_card[cur_idx];

`ifdef CARD_SEL_SKIP_EMPTY_EN
    logic [CARD_W-1:0] cur_type;
    assign cur_type    = map[int'(cur_idx)*CARD_W +: CARD_W];
    assign set_allowed = (cur_type != EMPTY_CARD);
`else
    logic unused_map;
    assign unused_map  = ^map;
    assign set_allowed = 1'b1;
`endif

    // Clearing a bit is always allowed; only setting can be blocked.
    assign tog_ok = toggle && !clear_all && !commit_req && (cur_bit || set_allowed);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        sel_d   = sel_card;
        count_d = sel_count;
        case (state_q)
            ST_IDLE: begin
                if (tog_ok) begin
                    sel_d[cur_idx] = ~cur_bit;
                    count_d        = cur_bit ? sel_count - 8'd1 : sel_count + 8'd1;
                end
                if (clear_all) begin
                    state_d = ST_CLEAR;
                    row_d   = '0;
                end else if (commit_req) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_CLEAR: begin
                sel_d[int'(row_q)*COLS +: COLS] = '0;
                if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    count_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            ST_COMMIT: begin
                if (commit_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            sel_card     <= '0;
            sel_count    <= '0;
            commit_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            sel_card     <= sel_d;
            sel_count    <= count_d;
            commit_valid <= (state_d == ST_COMMIT);
            busy         <= (state_d != ST_IDLE);
        end
    end

endmodule
